// File: rtl/cache_ctrl_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cache_ctrl_param
// Parametrised direct-mapped, write-through cache controller sitting between
// the CPU load/store port and the tag store, data array and main memory.
// After reset it walks every line of the tag store and clears it. Reads that
// miss refill a whole block from memory one word per memory ack. Writes always
// go to memory; they update the data array only when the line hits. With
// WRITE_ALLOC=1 a write miss first refills the block and is then retried.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_cpu_rd, i_cpu_wr        CPU requests (held stable while o_stall=1)
//   i_cpu_adr                 CPU word address {tag, index, offset}
//   i_tag_in, i_valid_in      tag-store read of line o_block_num
//   i_mem_ack                 memory completed the current beat
//   o_stall                   CPU must hold its request
//   o_hit                     looked-up line matches and is valid (IDLE only)
//   o_block_num               tag/data array line index
//   o_tag_we, o_tag_out,
//   o_valid_out               tag-store write strobe and data
//   o_we_cache                data-array write strobe
//   o_add_offset              data-array word select
//   o_fill_sel                data-array write source: 1 memory, 0 CPU
//   o_mem_req, o_mem_we       memory request, write-not-read
//   o_mem_adr                 memory word address
// ---------------------------------------------------------------------------
module cache_ctrl_param #(
    parameter int   ADDR_W      = 10,
    parameter int   INDEX_W     = 5,
    parameter int   WORD_OFF_W  = 2,
    parameter int   WRITE_ALLOC = 0,
    localparam int  TAG_W       = ADDR_W - INDEX_W - WORD_OFF_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_rd,
    input  logic                  i_cpu_wr,
    input  logic [ADDR_W-1:0]     i_cpu_adr,
    input  logic [TAG_W-1:0]      i_tag_in,
    input  logic                  i_valid_in,
    input  logic                  i_mem_ack,
    output logic                  o_stall,
    output logic                  o_hit,
    output logic [INDEX_W-1:0]    o_block_num,
    output logic                  o_tag_we,
    output logic [TAG_W-1:0]      o_tag_out,
    output logic                  o_valid_out,
    output logic                  o_we_cache,
    output logic [WORD_OFF_W-1:0] o_add_offset,
    output logic                  o_fill_sel,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_adr
);

    // One counter serves both the init walk (line index) and the refill (word).
    localparam int CNT_W = (INDEX_W > WORD_OFF_W) ? INDEX_W : WORD_OFF_W;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_REFILL = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;

    logic [TAG_W-1:0]      w_cpu_tag;
    logic [INDEX_W-1:0]    w_cpu_index;
    logic [WORD_OFF_W-1:0] w_cpu_offset;
    logic                  w_tag_match;
    logic                  w_refill_go;
    logic                  w_write_go;
    logic                  w_init_last;
    logic                  w_beat_last;

    assign w_cpu_tag    = i_cpu_adr[ADDR_W-1 -: TAG_W];
    assign w_cpu_index  = i_cpu_adr[WORD_OFF_W +: INDEX_W];
    assign w_cpu_offset = i_cpu_adr[WORD_OFF_W-1:0];
    assign w_tag_match  = i_valid_in && (i_tag_in == w_cpu_tag);

    // Reads win over writes; a write miss refills first only in allocate mode.
    assign w_refill_go  = (i_cpu_rd && !w_tag_match)
                       || (!i_cpu_rd && i_cpu_wr && (WRITE_ALLOC != 0) && !w_tag_match);
    assign w_write_go   = !i_cpu_rd && i_cpu_wr && !w_refill_go;
    assign w_init_last  = (r_cnt[INDEX_W-1:0] == {INDEX_W{1'b1}});
    assign w_beat_last  = (r_cnt[WORD_OFF_W-1:0] == {WORD_OFF_W{1'b1}});

    assign o_hit = !i_rst && (r_state == S_IDLE) && w_tag_match;

    // State and counter sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_INIT;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_INIT: begin
                    if (w_init_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (w_refill_go) begin
                        r_state <= S_REFILL;
                    end else if (w_write_go) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFILL: begin
                    if (i_mem_ack && w_beat_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else if (i_mem_ack) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt   <= r_cnt;
                    end
                end
                S_WRITE: begin
                    if (i_mem_ack) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from state, counter and current inputs.
    always_comb begin
        o_stall      = 1'b0;
        o_block_num  = {INDEX_W{1'b0}};
        o_tag_we     = 1'b0;
        o_tag_out    = {TAG_W{1'b0}};
        o_valid_out  = 1'b0;
        o_we_cache   = 1'b0;
        o_add_offset = {WORD_OFF_W{1'b0}};
        o_fill_sel   = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_adr    = {ADDR_W{1'b0}};
        if (i_rst) begin
            o_stall = 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    o_stall     = 1'b1;
                    o_block_num = r_cnt[INDEX_W-1:0];
                    o_tag_we    = 1'b1;
                end
                S_IDLE: begin
                    o_block_num  = w_cpu_index;
                    o_add_offset = w_cpu_offset;
                    if (w_refill_go) begin
                        // Invalidate the line so a broken-off refill never looks valid.
                        o_stall  = 1'b1;
                        o_tag_we = 1'b1;
                    end else if (w_write_go) begin
                        o_stall  = 1'b1;
                    end else begin
                        o_stall  = 1'b0;
                    end
                end
                S_REFILL: begin
                    o_stall     = 1'b1;
                    o_block_num = w_cpu_index;
                    o_mem_req   = 1'b1;
                    o_mem_adr   = {w_cpu_tag, w_cpu_index, r_cnt[WORD_OFF_W-1:0]};
                    if (i_mem_ack) begin
                        o_we_cache   = 1'b1;
                        o_fill_sel   = 1'b1;
                        o_add_offset = r_cnt[WORD_OFF_W-1:0];
                        if (w_beat_last) begin
                            o_tag_we    = 1'b1;
                            o_valid_out = 1'b1;
                            o_tag_out   = w_cpu_tag;
                        end else begin
                            o_tag_we    = 1'b0;
                        end
                    end else begin
                        o_we_cache = 1'b0;
                    end
                end
                S_WRITE: begin
                    o_block_num  = w_cpu_index;
                    o_add_offset = w_cpu_offset;
                    o_mem_req    = 1'b1;
                    o_mem_we     = 1'b1;
                    o_mem_adr    = i_cpu_adr;
                    if (i_mem_ack) begin
                        o_stall    = 1'b0;
                        o_we_cache = w_tag_match;
                    end else begin
                        o_stall    = 1'b1;
                    end
                end
                default: begin
                    o_stall = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_param.sv
`timescale 1ns/1ps
// Bench for cache_ctrl_param: one no-allocate instance (index 0) and one
// write-allocate instance (index 1), each with its own tag store and memory.
module tb_cache_ctrl_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       junk_fill = 1'b0;
    logic       rd_v [2];
    logic       wr_v [2];
    logic       ack_v [2];
    logic [9:0] adr_v [2];
    logic [2:0] tag_in_v [2];
    logic       valid_in_v [2];

    logic       stall_o [2];
    logic       hit_o [2];
    logic [4:0] blk_o [2];
    logic       tag_we_o [2];
    logic [2:0] tag_out_o [2];
    logic       valid_out_o [2];
    logic       we_o [2];
    logic [1:0] off_o [2];
    logic       fill_o [2];
    logic       mem_req_o [2];
    logic       mem_we_o [2];
    logic [9:0] mem_adr_o [2];

    // Environment tag store written by the DUT strobes.
    logic [2:0] ts_t [2][32];
    logic       ts_v [2][32];

    // Reference model of line contents.
    logic [2:0] ref_t [2][32];
    bit         ref_v [2][32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_ctrl_param #(.WRITE_ALLOC(0)) dut_na (
        .i_clk(clk), .i_rst(rst), .i_cpu_rd(rd_v[0]), .i_cpu_wr(wr_v[0]),
        .i_cpu_adr(adr_v[0]), .i_tag_in(tag_in_v[0]), .i_valid_in(valid_in_v[0]),
        .i_mem_ack(ack_v[0]), .o_stall(stall_o[0]), .o_hit(hit_o[0]),
        .o_block_num(blk_o[0]), .o_tag_we(tag_we_o[0]), .o_tag_out(tag_out_o[0]),
        .o_valid_out(valid_out_o[0]), .o_we_cache(we_o[0]), .o_add_offset(off_o[0]),
        .o_fill_sel(fill_o[0]), .o_mem_req(mem_req_o[0]), .o_mem_we(mem_we_o[0]),
        .o_mem_adr(mem_adr_o[0]));

    cache_ctrl_param #(.WRITE_ALLOC(1)) dut_wa (
        .i_clk(clk), .i_rst(rst), .i_cpu_rd(rd_v[1]), .i_cpu_wr(wr_v[1]),
        .i_cpu_adr(adr_v[1]), .i_tag_in(tag_in_v[1]), .i_valid_in(valid_in_v[1]),
        .i_mem_ack(ack_v[1]), .o_stall(stall_o[1]), .o_hit(hit_o[1]),
        .o_block_num(blk_o[1]), .o_tag_we(tag_we_o[1]), .o_tag_out(tag_out_o[1]),
        .o_valid_out(valid_out_o[1]), .o_we_cache(we_o[1]), .o_add_offset(off_o[1]),
        .o_fill_sel(fill_o[1]), .o_mem_req(mem_req_o[1]), .o_mem_we(mem_we_o[1]),
        .o_mem_adr(mem_adr_o[1]));

    assign tag_in_v[0]   = ts_t[0][blk_o[0]];
    assign valid_in_v[0] = ts_v[0][blk_o[0]];
    assign tag_in_v[1]   = ts_t[1][blk_o[1]];
    assign valid_in_v[1] = ts_v[1][blk_o[1]];

    // Tag-store RAM behaviour; junk_fill preloads garbage that init must clear.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (junk_fill) begin
                for (int i = 0; i < 32; i++) begin
                    ts_v[d][i] <= 1'b1;
                    ts_t[d][i] <= 3'($urandom);
                end
            end else if (tag_we_o[d]) begin
                ts_v[d][blk_o[d]] <= valid_out_o[d];
                ts_t[d][blk_o[d]] <= tag_out_o[d];
            end
        end
    end

    task automatic clear_ref();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) begin
                ref_v[d][i] = 1'b0;
                ref_t[d][i] = 3'd0;
            end
    endtask

    // Called right after the negedge where rst was released.
    task automatic init_walk();
        bit ok = 1'b1;
        bit clean = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!(tag_we_o[0] && !valid_out_o[0] && stall_o[0] && blk_o[0] == 5'(i)
                  && tag_out_o[0] == 3'd0 && !mem_req_o[0] && !we_o[0])) begin
                if (ok) $display("FAIL init_walk step %0d: tag_we=%0b valid_out=%0b stall=%0b block=%0d",
                                 i, tag_we_o[0], valid_out_o[0], stall_o[0], blk_o[0]);
                ok = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (!ok) n_fail++;
        n_checks++;
        if (stall_o[0] !== 1'b0 || tag_we_o[0] !== 1'b0 || stall_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL init_done: stall0=%0b tag_we0=%0b stall1=%0b required 0 0 0",
                     stall_o[0], tag_we_o[0], stall_o[1]);
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++)
                if (ts_v[d][i] !== 1'b0) clean = 1'b0;
        n_checks++;
        if (!clean) begin
            n_fail++;
            $display("FAIL init_clear: tag store has valid lines after init, required none");
        end
        clear_ref();
    endtask

    task automatic test_reset();
        bit ok = 1'b1;
        @(negedge clk);
        junk_fill = 1'b1;
        @(negedge clk);
        junk_fill = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (!(stall_o[0] && !hit_o[0] && !tag_we_o[0] && !we_o[0] && !mem_req_o[0]
                  && !mem_we_o[0] && blk_o[0] == 5'd0 && mem_adr_o[0] == 10'd0 && !fill_o[0]))
                ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_outputs: outputs not all 0 with stall=1 during reset");
        end
        rst = 1'b0;
        init_walk();
    endtask

    task automatic test_idle();
        @(negedge clk);
        adr_v[0] = 10'($urandom);
        #1;
        n_checks++;
        if (stall_o[0] !== 1'b0 || tag_we_o[0] !== 1'b0 || we_o[0] !== 1'b0 || mem_req_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: stall=%0b tag_we=%0b we=%0b mem_req=%0b required all 0",
                     stall_o[0], tag_we_o[0], we_o[0], mem_req_o[0]);
        end
    endtask

    task automatic test_read_miss();
        logic [9:0] e_adr;
        @(negedge clk);
        rd_v[0] = 1'b1; adr_v[0] = 10'h2C6; ack_v[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if (c == 0) begin
                if (!(tag_we_o[0] && !valid_out_o[0] && stall_o[0] && !mem_req_o[0])) begin
                    n_fail++;
                    $display("FAIL rm_c0: tag_we=%0b valid_out=%0b stall=%0b required 1 0 1",
                             tag_we_o[0], valid_out_o[0], stall_o[0]);
                end
            end else if (c < 5) begin
                e_adr = 10'h2C4 + 10'(c - 1);
                if (!(mem_req_o[0] && !mem_we_o[0] && mem_adr_o[0] == e_adr && we_o[0] && fill_o[0]
                      && off_o[0] == 2'(c - 1) && stall_o[0]
                      && (c < 4 ? !tag_we_o[0] : (tag_we_o[0] && valid_out_o[0] && tag_out_o[0] == 3'd5)))) begin
                    n_fail++;
                    $display("FAIL rm_beat%0d: mem_adr=%h we=%0b fill=%0b off=%0d tag_we=%0b tag_out=%0d required %h 1 1 %0d",
                             c, mem_adr_o[0], we_o[0], fill_o[0], off_o[0], tag_we_o[0], tag_out_o[0], e_adr, c - 1);
                end
            end else begin
                if (!(hit_o[0] && !stall_o[0] && off_o[0] == 2'd2 && !mem_req_o[0])) begin
                    n_fail++;
                    $display("FAIL rm_rehit: hit=%0b stall=%0b off=%0d required 1 0 2",
                             hit_o[0], stall_o[0], off_o[0]);
                end
            end
        end
        @(negedge clk);
        rd_v[0] = 1'b0; ack_v[0] = 1'b0;
        ref_v[0][17] = 1'b1;
        ref_t[0][17] = 3'd5;
    endtask

    // Runs one CPU access on instance d with w wait cycles before each ack and
    // compares against what the model expects from the line contents.
    task automatic run_txn(input int d, input bit rd, input bit wr, input logic [9:0] adr, input int w);
        logic [2:0] tg;
        logic [4:0] ix;
        bit was_hit, refill, wr_phase, exp_fin_hit, fin_hit, done, unstable, prev_wait, beats_ok;
        int exp_stall, exp_fill, exp_cpu, exp_tagwe;
        int stall_n, fill_n, cpu_n, tagwe_n, wcnt;
        logic [9:0] exp_adr [$];
        bit         exp_we [$];
        logic [9:0] got_adr [$];
        bit         got_we [$];
        logic [9:0] prev_adr;
        bit         prev_we;
        tg = adr[9:7];
        ix = adr[6:2];
        was_hit  = ref_v[d][ix] && (ref_t[d][ix] == tg);
        wr_phase = !rd && wr;
        refill   = !was_hit && (rd || (wr && d == 1));
        exp_stall = 0; exp_fill = 0; exp_cpu = 0; exp_tagwe = 0;
        if (refill) begin
            exp_stall += 1 + 4 * (w + 1);
            exp_fill  = 4;
            exp_tagwe = 2;
            for (int k = 0; k < 4; k++) begin
                exp_adr.push_back({tg, ix, 2'(k)});
                exp_we.push_back(1'b0);
            end
            ref_v[d][ix] = 1'b1;
            ref_t[d][ix] = tg;
        end
        if (wr_phase) begin
            exp_stall += 1 + w;
            exp_adr.push_back(adr);
            exp_we.push_back(1'b1);
            exp_cpu = (was_hit || refill) ? 1 : 0;
        end
        exp_fin_hit = !wr_phase;
        stall_n = 0; fill_n = 0; cpu_n = 0; tagwe_n = 0; wcnt = 0;
        done = 0; unstable = 0; prev_wait = 0; fin_hit = 0; prev_adr = '0; prev_we = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            rd_v[d] = rd; wr_v[d] = wr; adr_v[d] = adr;
            #1;
            ack_v[d] = mem_req_o[d] && (wcnt == w);
            #1;
            if (mem_req_o[d]) begin
                if (prev_wait && (mem_adr_o[d] !== prev_adr || mem_we_o[d] !== prev_we)) unstable = 1;
                prev_adr  = mem_adr_o[d];
                prev_we   = mem_we_o[d];
                prev_wait = !ack_v[d];
                if (ack_v[d]) begin
                    got_adr.push_back(mem_adr_o[d]);
                    got_we.push_back(mem_we_o[d]);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                prev_wait = 0;
            end
            if (we_o[d]) begin
                if (fill_o[d]) fill_n++;
                else cpu_n++;
            end
            if (tag_we_o[d]) tagwe_n++;
            if (stall_o[d]) stall_n++;
            else begin
                done = 1;
                fin_hit = hit_o[d];
            end
        end
        @(negedge clk);
        rd_v[d] = 1'b0; wr_v[d] = 1'b0; ack_v[d] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL txn_timeout d%0d adr=%h: stall never dropped within 300 cycles", d, adr);
        end
        n_checks++;
        if (stall_n != exp_stall) begin
            n_fail++;
            $display("FAIL txn_stall d%0d adr=%h rd=%0b wr=%0b w=%0d: got %0d required %0d",
                     d, adr, rd, wr, w, stall_n, exp_stall);
        end
        beats_ok = (got_adr.size() == exp_adr.size());
        if (beats_ok)
            for (int k = 0; k < exp_adr.size(); k++)
                if (got_adr[k] !== exp_adr[k] || got_we[k] !== exp_we[k]) beats_ok = 0;
        n_checks++;
        if (!beats_ok) begin
            n_fail++;
            $display("FAIL txn_mem_beats d%0d adr=%h: got %0d beats required %0d (address/we sequence differs)",
                     d, adr, got_adr.size(), exp_adr.size());
        end
        n_checks++;
        if (unstable) begin
            n_fail++;
            $display("FAIL txn_mem_stable d%0d adr=%h: mem_adr/mem_we changed while waiting, required stable", d, adr);
        end
        n_checks++;
        if (fill_n != exp_fill || cpu_n != exp_cpu) begin
            n_fail++;
            $display("FAIL txn_we_cache d%0d adr=%h: fill=%0d cpu=%0d required %0d %0d",
                     d, adr, fill_n, cpu_n, exp_fill, exp_cpu);
        end
        n_checks++;
        if (tagwe_n != exp_tagwe) begin
            n_fail++;
            $display("FAIL txn_tag_we d%0d adr=%h: got %0d required %0d", d, adr, tagwe_n, exp_tagwe);
        end
        n_checks++;
        if (done && fin_hit != exp_fin_hit) begin
            n_fail++;
            $display("FAIL txn_final_hit d%0d adr=%h: got %0b required %0b", d, adr, fin_hit, exp_fin_hit);
        end
        n_checks++;
        if (ts_v[d][ix] !== ref_v[d][ix] || (ref_v[d][ix] && ts_t[d][ix] !== ref_t[d][ix])) begin
            n_fail++;
            $display("FAIL txn_tag_store d%0d line %0d: valid=%0b tag=%0d required %0b %0d",
                     d, ix, ts_v[d][ix], ts_t[d][ix], ref_v[d][ix], ref_t[d][ix]);
        end
    endtask

    task automatic test_write_miss();
        run_txn(0, 1'b0, 1'b1, 10'h346, 0);
        run_txn(1, 1'b1, 1'b0, 10'h2C6, 0);
        run_txn(1, 1'b0, 1'b1, 10'h346, 0);
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        rd_v[0] = 1'b1; adr_v[0] = 10'h3C6; ack_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_req_o[0] !== 1'b1 || mem_adr_o[0] !== 10'h3C5) begin
            n_fail++;
            $display("FAIL mid_refill_beat1: mem_req=%0b mem_adr=%h required 1 3c5", mem_req_o[0], mem_adr_o[0]);
        end
        @(negedge clk);
        rst = 1'b1; rd_v[0] = 1'b0;
        #1;
        n_checks++;
        if (mem_req_o[0] !== 1'b0 || we_o[0] !== 1'b0 || stall_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_refill: mem_req=%0b we=%0b stall=%0b required 0 0 1", mem_req_o[0], we_o[0], stall_o[0]);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_req_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_next_cycle: mem_req=%0b required 0", mem_req_o[0]);
        end
        @(negedge clk);
        rst = 1'b0; ack_v[0] = 1'b0;
        init_walk();
        run_txn(0, 1'b1, 1'b0, 10'h2C6, 0);
    endtask

    task automatic test_random();
        int kind;
        int d;
        logic [9:0] a;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            d    = $urandom_range(0, 1);
            a    = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom)};
            run_txn(d, kind != 1, kind != 0, a, $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd_v[d] = 1'b0; wr_v[d] = 1'b0; ack_v[d] = 1'b0; adr_v[d] = 10'd0;
        end
        clear_ref();
        test_reset();
        test_idle();
        test_read_miss();
        run_txn(0, 1'b1, 1'b0, 10'h2C6, 0);   // read hit
        run_txn(0, 1'b0, 1'b1, 10'h2C6, 3);   // write hit, 3 wait cycles
        test_write_miss();
        run_txn(0, 1'b1, 1'b1, 10'h0A5, 1);   // rd and wr together on a miss
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_param.md
# cache_ctrl_param

Parametrised direct-mapped cache controller, the successor to the fixed 10-bit-address, 4-word-block controller. Sits between the CPU load/store port and the tag store, data array and main-memory port. Adds generic address, index and block-size widths, a variable-latency memory handshake, write-allocate as a mode, and a hardware tag-store clear after reset.

## Interface
- ADDR_W, 10, word-address width
- INDEX_W, 5, index width; the cache has 2^INDEX_W lines
- WORD_OFF_W, 2, word-offset width; a block holds 2^WORD_OFF_W words
- TAG_W, ADDR_W-INDEX_W-WORD_OFF_W, derived; never overridden
- WRITE_ALLOC, 0, 0 = write-through no-allocate; 1 = write-through write-allocate
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- cpu_rd, cpu_wr  in  1  CPU requests; held with cpu_adr stable while stall=1
- cpu_adr  in  ADDR_W  address; tag=[ADDR_W-1 -: TAG_W], index=[WORD_OFF_W +: INDEX_W], offset=[WORD_OFF_W-1:0]
- tag_in, valid_in  in  TAG_W, 1  tag-store read of line block_num
- mem_ack  in  1  memory completed current beat; ignored when mem_req=0
- stall  out  1  CPU must hold its request
- hit  out  1  (tag_in==cpu tag) && valid_in && state==IDLE
- block_num  out  INDEX_W  tag/data array index
- tag_we, tag_out, valid_out  out  1, TAG_W, 1  tag-store write strobe and data
- WE_cache  out  1  data-array write strobe
- Add_offset  out  WORD_OFF_W  data-array word select
- fill_sel  out  1  data-array write source: 1 = memory, 0 = CPU
- mem_req, mem_we  out  1, 1  memory request, write-not-read
- mem_Adr  out  ADDR_W  memory word address

## Operation
- States: INIT, IDLE, REFILL, WRITE. Single counter cnt, width max(INDEX_W, WORD_OFF_W).
- RST=1: next state INIT, cnt=0. While RST=1, all outputs are 0 except stall=1.
- INIT: block_num=cnt, tag_we=1, valid_out=0, tag_out=0, stall=1; cnt++ each cycle. After writing index 2^INDEX_W-1, go to IDLE with cnt=0.
- IDLE: block_num=cpu index, Add_offset=cpu offset.
  - cpu_rd has priority over cpu_wr when both are high.
  - Read hit: stall=0; no state change.
  - Read miss: stall=1, tag_we=1, valid_out=0 (invalidate the line); go to REFILL.
  - Write: stall=1; go to WRITE. Exception: WRITE_ALLOC=1 and miss behaves as a read miss (refill first).
  - No request: stall=0, all strobes 0.
- REFILL: mem_req=1, mem_we=0, mem_Adr={cpu tag, index, cnt[WORD_OFF_W-1:0]}, stall=1.
  - On mem_ack: WE_cache=1, fill_sel=1, Add_offset=cnt, cnt++.
  - On the ack for the last word: also tag_we=1, valid_out=1, tag_out=cpu tag; go to IDLE, cnt=0.
  - The original request is re-looked-up in IDLE and now hits.
- WRITE: mem_req=1, mem_we=1, mem_Adr=cpu_adr, stall=1 until ack.
  - On mem_ack: stall=0, go to IDLE. If the line hits, WE_cache=1, fill_sel=0, Add_offset=cpu offset.
  - A write miss never touches the tag store or data array in WRITE.
- mem_req stays high with mem_Adr and mem_we stable until mem_ack. Every strobe is at most one cycle per ack.

## Timing
- All outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Read hit: 0 stall cycles.
- Read miss, zero-wait memory (mem_ack=1): 2^WORD_OFF_W+1 stall cycles. Each extra wait cycle on a beat adds one stall cycle.
- Write, zero-wait memory: 1 stall cycle; stall drops in the ack cycle.
- Init: 2^INDEX_W cycles after RST falls.
- RST during REFILL or WRITE: mem_req=0 from the next cycle, the partial line stays invalid, and INIT reruns. A pending mem_ack is ignored.

## Test plan
- Init: RST=1 for 2 cycles, then 0 → 32 cycles of tag_we=1, valid_out=0, block_num 0..31, stall=1; then stall=0 in IDLE.
- Read miss, cpu_adr=0x2C6 (tag 5, index 17, offset 2), valid_in=0, mem_ack=1:
  - c0: tag_we=1, valid_out=0.
  - c1..c4: mem_Adr 0x2C4..0x2C7, WE_cache=1, fill_sel=1, Add_offset 0..3.
  - c4: tag_we=1, valid_out=1, tag_out=5.
  - c5: with tag_in=5, valid_in=1, hit=1, stall=0, Add_offset=2.
- Write hit, cpu_adr=0x2C6, mem_ack after 3 wait cycles → mem_req=1, mem_we=1, mem_Adr=0x2C6 stable for 4 cycles; WE_cache=1 with fill_sel=0 only in the ack cycle; stall=0 in the same cycle.
- Write miss, tag_in≠5:
  - WRITE_ALLOC=0 → 1 memory write; WE_cache=0 and tag_we=0 throughout.
  - WRITE_ALLOC=1 → 4-beat refill, then a write hit with WE_cache=1.
- RST=1 after 2 refill beats → mem_req=0 next cycle; INIT walk observed; a subsequent read of 0x2C6 misses.
- cpu_rd=cpu_wr=1 on a miss → handled as a read: REFILL entered, mem_we=0.
